// File: rtl/div_const_pipe.sv
// div_const_pipe: streaming unsigned divide-by-constant.
// The dividend is cut into CHUNK-bit digits, most significant digit first,
// and each pipeline stage retires one digit using a remainder recurrence.
// Every stage reads its quotient digit and new remainder from constant tables
// that are built at elaboration time, so there is no runtime divider.
// Optional build macro: DIV_CONST_SELFCHK_EN. It appends a register stage that
// rebuilds q*D + r, compares the result with the original X and raises out_err
// on any disagreement.
//
// Handshake contract (both ports): a transfer happens on the rising edge where
// valid & ready are both high. A valid producer keeps its payload stable until
// that edge. in_ready is combinational from out_ready through the stall chain.
module div_const_pipe #(
    parameter int W     = 64,
    parameter int D     = 11,
    parameter int CHUNK = 6,
    parameter int TAGW  = 4,
    localparam int RW   = $clog2(D)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_x,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_q,
    output logic [RW-1:0]   out_r,
    output logic [TAGW-1:0] out_tag
`ifdef DIV_CONST_SELFCHK_EN
    ,
    output logic            out_err
`endif
);

    localparam int S   = (W + CHUNK - 1) / CHUNK;  // number of digit stages
    localparam int PW  = S * CHUNK;                // dividend width after zero padding
    localparam int RAD = 2 ** CHUNK;               // digit radix
    localparam int NT  = D * RAD;                  // table entries: every (r_in, digit) pair

    // Table entry i corresponds to t = r_in*2^CHUNK + digit, so i = t.
    function automatic logic [NT*CHUNK-1:0] gen_q_tbl();
        logic [NT*CHUNK-1:0] t;
        t = '0;
        for (int r = 0; r < D; r++) begin
            for (int x = 0; x < RAD; x++) begin
                t[(r*RAD + x)*CHUNK +: CHUNK] = CHUNK'((r*RAD + x) / D);
            end
        end
        return t;
    endfunction

    function automatic logic [NT*RW-1:0] gen_r_tbl();
        logic [NT*RW-1:0] t;
        t = '0;
        for (int r = 0; r < D; r++) begin
            for (int x = 0; x < RAD; x++) begin
                t[(r*RAD + x)*RW +: RW] = RW'((r*RAD + x) % D);
            end
        end
        return t;
    endfunction

    localparam logic [NT*CHUNK-1:0] Q_TBL = gen_q_tbl();
    localparam logic [NT*RW-1:0]    R_TBL = gen_r_tbl();

    // Per-stage payload. xr holds the digits not yet consumed, left-aligned.
    // qa accumulates quotient digits from the right.
    typedef struct packed {
`ifdef DIV_CONST_SELFCHK_EN
        logic [W-1:0]    xo;
`endif
        logic [TAGW-1:0] tag;
        logic [RW-1:0]   rem;
        logic [PW-1:0]   qa;
        logic [PW-1:0]   xr;
    } stage_t;

    // Retire the leading digit of s. Because rem < D, the index stays below NT.
    function automatic stage_t step(stage_t s);
        stage_t o;
        int     idx;
        o     = s;
        idx   = int'({s.rem, s.xr[PW-1 -: CHUNK]});
        o.rem = R_TBL[idx*RW +: RW];
        o.qa  = (s.qa << CHUNK) | PW'(Q_TBL[idx*CHUNK +: CHUNK]);
        o.xr  = s.xr << CHUNK;
        return o;
    endfunction

    logic [S:1] vld_q;
    logic [S:1] src_v;
    logic [S:1] go;
    logic       tail_go;
    logic       full_tail;
    stage_t     in_stg;
    stage_t     stg_q [1:S];
    stage_t     stg_d [1:S];

    // Bit k is the valid flag that feeds stage k; stage 1 is fed by the input port.
    assign src_v = S'({vld_q, in_valid});

    // Next payload for every stage. Stage 1 starts from r_in = 0.
    always_comb begin
        in_stg     = '0;
`ifdef DIV_CONST_SELFCHK_EN
        in_stg.xo  = in_x;
`endif
        in_stg.tag = in_tag;
        in_stg.xr  = PW'(in_x);
        stg_d[1]   = step(in_stg);
        for (int k = 2; k <= S; k++) begin
            stg_d[k] = step(stg_q[k-1]);
        end
    end

    // Stall chain. Stage k may load unless it and every stage after it are
    // full and the tail is blocked. This lets bubbles collapse.
    always_comb begin
        full_tail = 1'b1;
        go        = '0;
        for (int k = S; k >= 1; k--) begin
            full_tail = full_tail & vld_q[k];
            go[k]     = tail_go | ~full_tail;
        end
    end

    assign in_ready = go[1];

    // Stage registers. clr drops every valid bit and blocks the input for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 1; k <= S; k++) begin
                stg_q[k] <= '0;
            end
        end else if (clr) begin
            vld_q <= '0;
        end else begin
            for (int k = 1; k <= S; k++) begin
                if (go[k]) begin
                    vld_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        stg_q[k] <= stg_d[k];
                    end
                end
            end
        end
    end

`ifdef DIV_CONST_SELFCHK_EN
    localparam int CW = W + RW + 1;

    logic            chk_vld_q;
    logic [W-1:0]    chk_q_q;
    logic [RW-1:0]   chk_r_q;
    logic [TAGW-1:0] chk_tag_q;
    logic            chk_err_q;
    logic            chk_err_d;
    logic [CW-1:0]   recon;

    assign tail_go = ~chk_vld_q | out_ready;

    // Rebuild the dividend from the final quotient and remainder. Also flag an out-of-range remainder.
    always_comb begin
        recon     = CW'(stg_q[S].qa[W-1:0]) * CW'(D) + CW'(stg_q[S].rem);
        chk_err_d = (recon != CW'(stg_q[S].xo)) || (CW'(stg_q[S].rem) >= CW'(D));
    end

    // Check stage. It is one more slot in the pipe and obeys the same transfer rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vld_q <= 1'b0;
            chk_q_q   <= '0;
            chk_r_q   <= '0;
            chk_tag_q <= '0;
            chk_err_q <= 1'b0;
        end else if (clr) begin
            chk_vld_q <= 1'b0;
        end else if (tail_go) begin
            chk_vld_q <= vld_q[S];
            if (vld_q[S]) begin
                chk_q_q   <= stg_q[S].qa[W-1:0];
                chk_r_q   <= stg_q[S].rem;
                chk_tag_q <= stg_q[S].tag;
                chk_err_q <= chk_err_d;
            end
        end
    end

    assign out_valid = chk_vld_q;
    assign out_q     = chk_q_q;
    assign out_r     = chk_r_q;
    assign out_tag   = chk_tag_q;
    assign out_err   = chk_err_q;
`else
    assign tail_go   = out_ready;
    assign out_valid = vld_q[S];
    assign out_q     = stg_q[S].qa[W-1:0];
    assign out_r     = stg_q[S].rem;
    assign out_tag   = stg_q[S].tag;
`endif

endmodule

// File: tb/tb_div_const_pipe.sv
// tb_div_const_pipe: directed cases plus a randomized stream for div_const_pipe.
// Every accepted operand is scored against plain X/D and X%D arithmetic.
module tb_div_const_pipe;

    localparam int W     = 64;
    localparam int D     = 11;
    localparam int CHUNK = 6;
    localparam int TAGW  = 4;
    localparam int RW    = $clog2(D);
    localparam int S     = (W + CHUNK - 1) / CHUNK;
`ifdef DIV_CONST_SELFCHK_EN
    localparam int LAT   = S + 1;
`else
    localparam int LAT   = S;
`endif
    localparam int EW    = W + RW + TAGW;

    logic            clk;
    logic            rst_n;
    logic            clr;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_q;
    logic [RW-1:0]   out_r;
    logic [TAGW-1:0] out_tag;
`ifdef DIV_CONST_SELFCHK_EN
    logic            out_err;
`endif

    int            n_checks;
    int            n_errors;
    int            n_pop;
    int            full_depth;
    logic [EW-1:0] exp_q[$];

    div_const_pipe #(.W(W), .D(D), .CHUNK(CHUNK), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_tag   (out_tag)
`ifdef DIV_CONST_SELFCHK_EN
        ,
        .out_err   (out_err)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hang guard. Every wait below is bounded, so this should never fire.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer division of the operand, with the tag carried through.
    function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [TAGW-1:0] t);
        logic [W-1:0] q;
        logic [W-1:0] r;
        q = x / W'(D);
        r = x % W'(D);
        return {q, RW'(r), t};
    endfunction

    function automatic logic [W-1:0] rand_x();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 200));
            1:       return {32'hFFFF_FFFF, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- scoreboard / monitor ----------------
    // It samples at the falling edge. What it sees there is exactly what the next rising edge will act on.
    initial begin
        logic [EW-1:0] e;
        logic          st_prev;
        logic [W-1:0]  st_q;
        logic [RW-1:0] st_r;
        logic [TAGW-1:0] st_t;
        st_prev = 1'b0;
        st_q    = '0;
        st_r    = '0;
        st_t    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || clr) begin
                exp_q.delete();
                st_prev = 1'b0;
            end else begin
                if (st_prev) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_q", 64'(out_q), 64'(st_q));
                    check("stall_r_tag", 64'({out_r, out_tag}), 64'({st_r, st_t}));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_result", 64'(out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        n_pop++;
                        check("sb_q", 64'(out_q), 64'(e[EW-1 -: W]));
                        check("sb_r", 64'(out_r), 64'(e[TAGW +: RW]));
                        check("sb_tag", 64'(out_tag), 64'(e[TAGW-1:0]));
`ifdef DIV_CONST_SELFCHK_EN
                        check("sb_err", 64'(out_err), 64'd0);
`endif
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_x, in_tag));
                end
                st_prev = out_valid && !out_ready;
                st_q    = out_q;
                st_r    = out_r;
                st_t    = out_tag;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call at posedge+1. Holds the operand until accepted and returns at posedge+1 after the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [TAGW-1:0] t, output int waits);
        logic acc;
        in_valid = 1'b1;
        in_x     = x;
        in_tag   = t;
        waits    = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            if (!acc && full_depth < 0) full_depth = exp_q.size();
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Returns at the falling edge where out_valid is first high.
    // n is the number of rising edges since the caller's last edge.
    task automatic wait_valid(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 200) begin
                check("wait_valid_timeout", 64'(out_valid), 64'd1);
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int           w;
        int           w3;
        int           lat;
        int           cnt;
        int           n0;
        bit           done;
        logic [W-1:0] t2_x [4];
        logic [W-1:0] t2_q [4];
        logic [RW-1:0] t2_r [4];

        n_checks   = 0;
        n_errors   = 0;
        n_pop      = 0;
        full_depth = -1;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_x       = '0;
        in_tag     = '0;
        out_ready  = 1'b1;
        rst_n      = 1'b1;
        #2;
        rst_n      = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_q", 64'(out_q), 64'd0);
        check("rst_out_r", 64'(out_r), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // All-ones dividend: known quotient, remainder and latency.
        send(64'hFFFF_FFFF_FFFF_FFFF, 4'd3, w);
        wait_valid(lat);
        check("t1_latency", 64'(lat + 1), 64'(LAT));
        check("t1_q", 64'(out_q), 64'h1745_D174_5D17_45D1);
        check("t1_r", 64'(out_r), 64'd4);
        check("t1_tag", 64'(out_tag), 64'd3);
        @(posedge clk);
        #1;

        // Back-to-back small values around the divisor.
        t2_x = '{64'd0, 64'd10, 64'd11, 64'd12};
        t2_q = '{64'd0, 64'd0, 64'd1, 64'd1};
        t2_r = '{4'd0, 4'd10, 4'd0, 4'd1};
        for (int i = 0; i < 4; i++) begin
            send(t2_x[i], 4'(i), w);
            check("t2_in_ready", 64'(w), 64'd0);
        end
        wait_valid(lat);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("t2_valid", 64'(out_valid), 64'd1);
            check("t2_q", 64'(out_q), 64'(t2_q[i]));
            check("t2_r", 64'(out_r), 64'(t2_r[i]));
        end
        @(posedge clk);
        #1;

        // Backpressure: fill every stage, then release.
        n0         = n_pop;
        full_depth = -1;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = !(c >= 5 && c <= 30);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    send(rand_x(), 4'($urandom_range(0, 15)), w3);
                end
            end
        join
        drain("t3_drained");
        check("t3_count", 64'(n_pop - n0), 64'd20);
        check("t3_full_depth", 64'(full_depth), 64'(LAT));
        @(posedge clk);
        #1;

        // Flush with five operands in flight while a sixth is offered.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(rand_x(), 4'(i), w);
        end
        clr      = 1'b1;
        in_valid = 1'b1;
        in_x     = rand_x();
        in_tag   = 4'hA;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_clr_valid", 64'(out_valid), 64'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("t4_no_stale", 64'(cnt), 64'd0);
        @(posedge clk);
        #1;
        send(64'd22, 4'd5, w);
        wait_valid(lat);
        check("t4_latency", 64'(lat + 1), 64'(LAT));
        check("t4_q", 64'(out_q), 64'd2);
        check("t4_r", 64'(out_r), 64'd0);
        check("t4_tag", 64'(out_tag), 64'd5);
        @(posedge clk);
        #1;

        // Asynchronous reset while a result is held at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(64'h8000_0000_0000_0000 | rand_x(), 4'(i + 8), w);
        end
        wait_valid(lat);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_q", 64'(out_q), 64'd0);
        check("t5_r", 64'(out_r), 64'd0);
        check("t5_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(64'd121, 4'd6, w);
        wait_valid(lat);
        check("t5_new_q", 64'(out_q), 64'd11);
        check("t5_new_r", 64'(out_r), 64'd0);
        check("t5_new_tag", 64'(out_tag), 64'd6);
        @(posedge clk);
        #1;

        // Randomized stream with random gaps and random backpressure.
        n0   = n_pop;
        done = 1'b0;
        fork
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_x(), 4'($urandom_range(0, 15)), w3);
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
        join
        drain("rand_drained");
        check("rand_count", 64'(n_pop - n0), 64'd300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
